arbitro_de_funcionalidades: RTL and testbench
=============================================

Name: arbitro_de_funcionalidades

Overview:
- Registered, parametrised arbiter for NUM_CH user channels. Each channel presents a (user code, function code) request.
- Checks each request against a per-user permission mask, then allocates each function to at most one channel per cycle.
- Holds each grant for a minimum time; a strictly higher-priority user may preempt once that time has expired.
- Sits between the switch/button front end and the LED matrix, LED and 7-segment drivers. Its outputs feed those decoders directly.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- USER_W, 3, user code width. Code 0 = no user. Larger code = higher priority.
- FUNC_W, 3, function code width. Code 0 = neutral (no request). NUM_FUNCS = 2**FUNC_W.
- MIN_HOLD, 4, minimum cycles a grant is kept before preemption (>=1).
- PERM_MASK, 64'h0000_FE00_0000_0A00, bit [u*NUM_FUNCS+f] = user u may use function f. Default: user 1 may use {1,3}; user 5 may use {1..7}; all other users may use nothing.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- ReqUser  in  NUM_CH*USER_W  channel i user code at [i*USER_W +: USER_W].
- ReqFunc  in  NUM_CH*FUNC_W  channel i function code at [i*FUNC_W +: FUNC_W].
- Grant  out  NUM_CH  channel i currently owns its requested function.
- Denied  out  NUM_CH  channel i request is non-neutral but not permitted.
- FuncActive  out  NUM_FUNCS  bit f = function f has an owner. Bit 0 is always 0.
- LoserValid  out  1  at least one permitted request is waiting.
- LoserUser  out  USER_W  highest user code among waiting requests; 0 if none.

Behaviour:
- One clock domain: Clock. Reset is synchronous and active-high.
- While Reset=1, every output is 0 and every slot is LIVRE, regardless of inputs. Requests are evaluated on the first edge with Reset=0.
- All outputs are registered. Latency is 1 edge: inputs sampled at edge E drive outputs visible after E.
- A request from channel i is valid when func!=0, user!=0 and PERM_MASK[user*NUM_FUNCS+func]=1.
- Denied[i] = func!=0 and not permitted (including user=0). Denied channels never receive a grant.
- One slot per function f>=1, each with its own FSM:
  - LIVRE: no owner. If any valid requester of f exists, go to OCUPADO with owner = highest user code; tie goes to the lowest channel index. Set count=1.
  - OCUPADO: if the owner no longer requests f (func changed, neutral, or now denied), release.
    - On release, if another valid requester exists, hand over in the same edge to the best one, with count=1.
    - Otherwise return to LIVRE.
  - OCUPADO, owner still requesting: count saturates at MIN_HOLD.
    - If count==MIN_HOLD and some requester has a strictly higher user code, preempt to that requester (tie: lowest index), count=1.
    - An equal user code never preempts the incumbent.
- Distinct functions are independent, so several channels can be granted in the same cycle. A channel requests exactly one function, so it holds at most one grant.
- Grant[i] = i is owner of slot ReqFunc[i]. FuncActive[f] = slot f OCUPADO.
- Waiting set = valid requesters that are not owners. LoserUser = maximum user code in that set; LoserValid = set non-empty.
- Mid-operation Reset: clears all slots and counts on that edge. No grant survives.

Decomposition:
- Package arbitro_pkg holds:
  - constants USER_NONE=0 and FUNC_NEUTRAL=0;
  - the permission-lookup function;
  - the priority-compare function (higher code, then lower index).
- One sub-module, slot_de_funcionalidade, instantiated NUM_FUNCS-1 times by generate.
  - Inputs: per-channel valid-for-f vector and user codes.
  - Outputs: owner index, owned flag, count, registered.
- The top level builds the valid/Denied vectors, ORs the slot results into Grant/FuncActive, and computes Loser*.

Test Plan (defaults):
- Reset held 3 cycles with ch0=(5,1) and ch1=(1,1) → Grant=00, FuncActive=0, Denied=00, LoserValid=0. First edge after release → Grant=01, FuncActive=8'h02.
- Conflict: ch0=(5,1), ch1=(1,1) applied together → after 1 edge Grant=01, LoserValid=1, LoserUser=1.
- Distinct: ch0=(5,2), ch1=(1,1) → Grant=11, FuncActive=8'h06, LoserValid=0.
- Permission: ch1=(1,2), ch0 neutral → Denied=10, Grant=00, FuncActive=0.
- Preemption: ch1=(1,1) granted at edge E0, then ch0=(5,1) from E1 on.
  - E1..E3: Grant=10, LoserUser=5.
  - E4: Grant=01, LoserUser=1.
  - Equal-code case ch0=(1,1): never preempts.
- Release handover plus mid-hold Reset: owner ch0 goes neutral while ch1=(1,1) waits → ch1 granted on that same edge. Reset=1 asserted at count=2 → all outputs 0 on the next edge.

Source files
------------

// File: rtl/arbitro_de_funcionalidades_pkg.sv
// Shared constants, slot state encoding and the permission / priority helpers
// used by the function arbiter and its per-function slots.
package arbitro_pkg;

  localparam int unsigned USER_NONE    = 0;
  localparam int unsigned FUNC_NEUTRAL = 0;
  localparam int unsigned PERM_MAX_W   = 1024;
  localparam int unsigned PERM_IDX_W   = 10;

  typedef enum logic {
    LIVRE   = 1'b0,
    OCUPADO = 1'b1
  } slot_state_t;

  // Out-of-range indices, user 0 and the neutral function are never permitted.
  function automatic logic perm_ok(input logic [PERM_MAX_W-1:0] mask,
                                   input int unsigned user,
                                   input int unsigned func,
                                   input int unsigned num_funcs);
    int unsigned bit_idx;
    bit_idx = user * num_funcs + func;
    if (func == FUNC_NEUTRAL || user == USER_NONE || bit_idx >= PERM_MAX_W) return 1'b0;
    return mask[bit_idx[PERM_IDX_W-1:0]];
  endfunction

  // True when requester a outranks b: higher user code, then lower channel index.
  function automatic logic beats(input int unsigned user_a, input int unsigned idx_a,
                                 input int unsigned user_b, input int unsigned idx_b);
    return (user_a > user_b) || ((user_a == user_b) && (idx_a < idx_b));
  endfunction

endpackage

// File: rtl/arbitro_de_funcionalidades_if.sv
// Request/grant bundle between the front end (master) and the arbiter (slave).
interface arbitro_de_funcionalidades_if #(
  parameter int NUM_CH = 2,
  parameter int USER_W = 3,
  parameter int FUNC_W = 3
);
  localparam int NUM_FUNCS = 2 ** FUNC_W;

  logic [NUM_CH*USER_W-1:0] ReqUser;
  logic [NUM_CH*FUNC_W-1:0] ReqFunc;
  logic [NUM_CH-1:0]        Grant;
  logic [NUM_CH-1:0]        Denied;
  logic [NUM_FUNCS-1:0]     FuncActive;
  logic                     LoserValid;
  logic [USER_W-1:0]        LoserUser;

  modport master (output ReqUser, ReqFunc,
                  input  Grant, Denied, FuncActive, LoserValid, LoserUser);
  modport slave  (input  ReqUser, ReqFunc,
                  output Grant, Denied, FuncActive, LoserValid, LoserUser);
endinterface

// File: rtl/arbitro_de_funcionalidades_slot.sv
// Ownership FSM for one function: allocation, release handover and
// preemption after the minimum hold time.
module slot_de_funcionalidade
  import arbitro_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int USER_W   = 3,
  parameter int MIN_HOLD = 4,
  parameter int IDX_W    = $clog2(NUM_CH),
  parameter int CNT_W    = $clog2(MIN_HOLD + 1)
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH*USER_W-1:0] users,
  output logic [IDX_W-1:0]         owner,
  output logic                     owned,
  output logic [CNT_W-1:0]         count
);

  slot_state_t       state_reg, state_next;
  logic [IDX_W-1:0]  owner_reg, owner_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic              best_found;
  logic [IDX_W-1:0]  best_idx;
  logic [USER_W-1:0] best_user;
  logic              owner_valid;
  logic [USER_W-1:0] owner_user;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= LIVRE;
      owner_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      count_reg <= count_next;
    end
  end

  // Best valid requester overall, plus what the current owner is asking for.
  always_comb begin
    best_found  = 1'b0;
    best_idx    = '0;
    best_user   = '0;
    owner_valid = 1'b0;
    owner_user  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (valid[i] && (!best_found ||
          beats(32'(users[i*USER_W +: USER_W]), unsigned'(i),
                32'(best_user), 32'(best_idx)))) begin
        best_found = 1'b1;
        best_idx   = IDX_W'(i);
        best_user  = users[i*USER_W +: USER_W];
      end
      if (IDX_W'(i) == owner_reg) begin
        owner_valid = valid[i];
        owner_user  = users[i*USER_W +: USER_W];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    count_next = count_reg;
    case (state_reg)
      LIVRE: begin
        if (best_found) begin
          state_next = OCUPADO;
          owner_next = best_idx;
          count_next = CNT_W'(1);
        end
      end
      OCUPADO: begin
        if (!owner_valid) begin
          // The owner cannot be the best here, so handover picks someone else.
          if (best_found) begin
            owner_next = best_idx;
            count_next = CNT_W'(1);
          end else begin
            state_next = LIVRE;
            owner_next = '0;
            count_next = '0;
          end
        end else if (count_reg == CNT_W'(MIN_HOLD) && best_found && best_user > owner_user) begin
          owner_next = best_idx;
          count_next = CNT_W'(1);
        end else if (count_reg != CNT_W'(MIN_HOLD)) begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: state_next = LIVRE;
    endcase
  end

  always_comb begin
    owned = (state_reg == OCUPADO);
    owner = owner_reg;
    count = count_reg;
  end

endmodule

// File: rtl/arbitro_de_funcionalidades.sv
// Function arbiter: permission filtering, one ownership slot per non-neutral
// function, and registered grant / denial / waiting-user reporting.
module arbitro_de_funcionalidades
  import arbitro_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int USER_W   = 3,
  parameter int FUNC_W   = 3,
  parameter int MIN_HOLD = 4,
  parameter logic [2**(USER_W+FUNC_W)-1:0] PERM_MASK = 64'h0000_FE00_0000_0A00
) (
  input  logic Clock,
  input  logic Reset,
  arbitro_de_funcionalidades_if.slave bus
);

  localparam int NUM_FUNCS = 2 ** FUNC_W;
  localparam int IDX_W     = $clog2(NUM_CH);
  localparam int CNT_W     = $clog2(MIN_HOLD + 1);
  localparam logic [PERM_MAX_W-1:0] PERM_EXT = PERM_MAX_W'(PERM_MASK);

  logic [FUNC_W-1:0]             ch_func [NUM_CH];
  logic [NUM_CH-1:0]             req_ok;
  logic [NUM_CH-1:0]             req_denied;

  logic [NUM_CH*USER_W-1:0]      user_reg;
  logic [NUM_CH-1:0]             valid_reg;
  logic [NUM_CH-1:0]             denied_reg;

  logic [IDX_W-1:0]              slot_owner [1:NUM_FUNCS-1];
  logic [NUM_FUNCS-1:1]          slot_owned;
  logic [(NUM_FUNCS-1)*CNT_W-1:0] slot_count_flat;
  wire                           unused_slot_count = ^slot_count_flat;

  logic [NUM_CH-1:0]             grant;
  logic                          loser_valid;
  logic [USER_W-1:0]             loser_user;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [USER_W-1:0] ch_user;
      assign ch_user      = bus.ReqUser[gi*USER_W +: USER_W];
      assign ch_func[gi]  = bus.ReqFunc[gi*FUNC_W +: FUNC_W];
      assign req_ok[gi]   = perm_ok(PERM_EXT, 32'(ch_user), 32'(ch_func[gi]), NUM_FUNCS);
      assign req_denied[gi] = (32'(ch_func[gi]) != FUNC_NEUTRAL) && !req_ok[gi];
    end

    for (gi = 1; gi < NUM_FUNCS; gi++) begin : g_slot
      logic [NUM_CH-1:0] valid_f;
      always_comb begin
        valid_f = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          valid_f[c] = req_ok[c] && (ch_func[c] == FUNC_W'(gi));
        end
      end

      slot_de_funcionalidade #(
        .NUM_CH  (NUM_CH),
        .USER_W  (USER_W),
        .MIN_HOLD(MIN_HOLD),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
      ) u_slot (
        .clk   (Clock),
        .srst  (Reset),
        .valid (valid_f),
        .users (bus.ReqUser),
        .owner (slot_owner[gi]),
        .owned (slot_owned[gi]),
        .count (slot_count_flat[(gi-1)*CNT_W +: CNT_W])
      );
    end
  endgenerate

  // Snapshot of the sampled requests so the waiting-set report lines up with the slots.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      user_reg   <= '0;
      valid_reg  <= '0;
      denied_reg <= '0;
    end else begin
      user_reg   <= bus.ReqUser;
      valid_reg  <= req_ok;
      denied_reg <= req_denied;
    end
  end

  always_comb begin
    grant = '0;
    for (int f = 1; f < NUM_FUNCS; f++) begin
      if (slot_owned[f]) grant[slot_owner[f]] = 1'b1;
    end
  end

  always_comb begin
    loser_valid = 1'b0;
    loser_user  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (valid_reg[i] && !grant[i]) begin
        loser_valid = 1'b1;
        if (user_reg[i*USER_W +: USER_W] > loser_user) loser_user = user_reg[i*USER_W +: USER_W];
      end
    end
  end

  assign bus.Grant      = grant;
  assign bus.Denied     = denied_reg;
  assign bus.FuncActive = {slot_owned, 1'b0};
  assign bus.LoserValid = loser_valid;
  assign bus.LoserUser  = loser_user;

endmodule

// File: tb/tb_arbitro_de_funcionalidades.sv
// Directed scenarios for the function arbiter with hand-computed expectations.
module tb_arbitro_de_funcionalidades;

  logic Clock;
  logic Reset;
  int   pass_cnt;
  int   total_cnt;

  arbitro_de_funcionalidades_if #(.NUM_CH(2), .USER_W(3), .FUNC_W(3)) bus ();

  arbitro_de_funcionalidades #(
    .NUM_CH  (2),
    .USER_W  (3),
    .FUNC_W  (3),
    .MIN_HOLD(4),
    .PERM_MASK(64'h0000_FE00_0000_0A00)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input int u, input int f);
    bus.ReqUser[ch*3 +: 3] = 3'(u);
    bus.ReqFunc[ch*3 +: 3] = 3'(f);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    set_ch(0, 0, 0);
    set_ch(1, 0, 0);
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_ch(0, 5, 1);
    set_ch(1, 1, 1);
    step(); step(); step();
    total_cnt++; if (bus.Grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.FuncActive !== 8'h00) $display("FAIL reset_funcactive: got %h want 00", bus.FuncActive); else pass_cnt++;
    total_cnt++; if (bus.Denied !== 2'b00) $display("FAIL reset_denied: got %b want 00", bus.Denied); else pass_cnt++;
    total_cnt++; if (bus.LoserValid !== 1'b0) $display("FAIL reset_loservalid: got %b want 0", bus.LoserValid); else pass_cnt++;
    Reset = 1'b0;
    step();
    total_cnt++; if (bus.Grant !== 2'b01) $display("FAIL reset_release_grant: got %b want 01", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.FuncActive !== 8'h02) $display("FAIL reset_release_funcactive: got %h want 02", bus.FuncActive); else pass_cnt++;
    $display("test_reset done: Grant=%b FuncActive=%h", bus.Grant, bus.FuncActive);
  endtask

  task automatic test_conflict();
    do_reset();
    set_ch(0, 5, 1);
    set_ch(1, 1, 1);
    step();
    total_cnt++; if (bus.Grant !== 2'b01) $display("FAIL conflict_grant: got %b want 01", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.LoserValid !== 1'b1) $display("FAIL conflict_loservalid: got %b want 1", bus.LoserValid); else pass_cnt++;
    total_cnt++; if (bus.LoserUser !== 3'd1) $display("FAIL conflict_loseruser: got %0d want 1", bus.LoserUser); else pass_cnt++;
    $display("test_conflict done: Grant=%b LoserUser=%0d", bus.Grant, bus.LoserUser);
  endtask

  task automatic test_distinct();
    do_reset();
    set_ch(0, 5, 2);
    set_ch(1, 1, 1);
    step();
    total_cnt++; if (bus.Grant !== 2'b11) $display("FAIL distinct_grant: got %b want 11", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.FuncActive !== 8'h06) $display("FAIL distinct_funcactive: got %h want 06", bus.FuncActive); else pass_cnt++;
    total_cnt++; if (bus.LoserValid !== 1'b0) $display("FAIL distinct_loservalid: got %b want 0", bus.LoserValid); else pass_cnt++;
    $display("test_distinct done: Grant=%b FuncActive=%h", bus.Grant, bus.FuncActive);
  endtask

  task automatic test_permission();
    do_reset();
    set_ch(0, 0, 0);
    set_ch(1, 1, 2);
    step();
    total_cnt++; if (bus.Denied !== 2'b10) $display("FAIL perm_denied: got %b want 10", bus.Denied); else pass_cnt++;
    total_cnt++; if (bus.Grant !== 2'b00) $display("FAIL perm_grant: got %b want 00", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.FuncActive !== 8'h00) $display("FAIL perm_funcactive: got %h want 00", bus.FuncActive); else pass_cnt++;
    set_ch(0, 0, 3);
    step();
    total_cnt++; if (bus.Denied !== 2'b11) $display("FAIL perm_user0_denied: got %b want 11", bus.Denied); else pass_cnt++;
    total_cnt++; if (bus.LoserValid !== 1'b0) $display("FAIL perm_loservalid: got %b want 0", bus.LoserValid); else pass_cnt++;
    $display("test_permission done: Denied=%b Grant=%b", bus.Denied, bus.Grant);
  endtask

  task automatic test_preemption();
    do_reset();
    set_ch(1, 1, 1);
    step();
    total_cnt++; if (bus.Grant !== 2'b10) $display("FAIL preempt_e0_grant: got %b want 10", bus.Grant); else pass_cnt++;
    set_ch(0, 5, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      total_cnt++; if (bus.Grant !== 2'b10) $display("FAIL preempt_hold_grant e%0d: got %b want 10", k, bus.Grant); else pass_cnt++;
      total_cnt++; if (bus.LoserUser !== 3'd5) $display("FAIL preempt_hold_loser e%0d: got %0d want 5", k, bus.LoserUser); else pass_cnt++;
    end
    step();
    total_cnt++; if (bus.Grant !== 2'b01) $display("FAIL preempt_e4_grant: got %b want 01", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.LoserUser !== 3'd1) $display("FAIL preempt_e4_loser: got %0d want 1", bus.LoserUser); else pass_cnt++;
    $display("test_preemption done: Grant=%b LoserUser=%0d", bus.Grant, bus.LoserUser);
  endtask

  task automatic test_equal_code();
    do_reset();
    set_ch(1, 1, 1);
    step();
    set_ch(0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      total_cnt++; if (bus.Grant !== 2'b10) $display("FAIL equal_grant e%0d: got %b want 10", k, bus.Grant); else pass_cnt++;
    end
    total_cnt++; if (bus.LoserUser !== 3'd1) $display("FAIL equal_loser: got %0d want 1", bus.LoserUser); else pass_cnt++;
    $display("test_equal_code done: Grant=%b", bus.Grant);
  endtask

  task automatic test_handover_reset();
    do_reset();
    set_ch(0, 5, 1);
    step();
    set_ch(1, 1, 1);
    step();
    total_cnt++; if (bus.Grant !== 2'b01) $display("FAIL handover_pre_grant: got %b want 01", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.LoserValid !== 1'b1) $display("FAIL handover_pre_loservalid: got %b want 1", bus.LoserValid); else pass_cnt++;
    set_ch(0, 0, 0);
    step();
    total_cnt++; if (bus.Grant !== 2'b10) $display("FAIL handover_grant: got %b want 10", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.FuncActive !== 8'h02) $display("FAIL handover_funcactive: got %h want 02", bus.FuncActive); else pass_cnt++;
    total_cnt++; if (bus.LoserValid !== 1'b0) $display("FAIL handover_loservalid: got %b want 0", bus.LoserValid); else pass_cnt++;
    step();
    Reset = 1'b1;
    step();
    total_cnt++; if (bus.Grant !== 2'b00) $display("FAIL midreset_grant: got %b want 00", bus.Grant); else pass_cnt++;
    total_cnt++; if (bus.FuncActive !== 8'h00) $display("FAIL midreset_funcactive: got %h want 00", bus.FuncActive); else pass_cnt++;
    total_cnt++; if (bus.LoserValid !== 1'b0) $display("FAIL midreset_loservalid: got %b want 0", bus.LoserValid); else pass_cnt++;
    total_cnt++; if (bus.LoserUser !== 3'd0) $display("FAIL midreset_loseruser: got %0d want 0", bus.LoserUser); else pass_cnt++;
    Reset = 1'b0;
    $display("test_handover_reset done: Grant=%b", bus.Grant);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    Reset     = 1'b1;
    bus.ReqUser = '0;
    bus.ReqFunc = '0;
    test_reset();
    test_conflict();
    test_distinct();
    test_permission();
    test_preemption();
    test_equal_code();
    test_handover_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
